// File: rtl/sfifo_pkg.sv
// rtl/sfifo_pkg.sv - shared constants, count-width helper and status bundle for sfifo_param
//
// Purpose: common definitions for the parametrised synchronous FIFO and its integrators.
//   SFIFO_DATA_W_DEF / SFIFO_DEPTH_DEF : default data width and depth
//   sfifo_cnt_w(depth)                 : width of an occupancy count able to hold 0..depth
//   sfifo_status_t                     : packed flag/error bundle for integrating blocks
package sfifo_pkg;

    localparam int SFIFO_DATA_W_DEF = 8;
    localparam int SFIFO_DEPTH_DEF  = 16;

    function automatic int sfifo_cnt_w(input int depth);
        return $clog2(depth) + 1;
    endfunction

    typedef struct packed {
        logic full;
        logic empty;
        logic almost_full;
        logic almost_empty;
        logic overflow;
        logic underflow;
    } sfifo_status_t;

endpackage

// File: rtl/sfifo_mem.sv
// rtl/sfifo_mem.sv - DATA_W x DEPTH register array, one write port, one async read port
//
// Purpose: storage for sfifo_param. Contents are deliberately not reset.
// Ports:
//   clk   in  rising-edge clock
//   wen   in  write enable
//   waddr in  write address
//   wdata in  write data
//   raddr in  read address
//   rdata out combinational read data at raddr
module sfifo_mem #(
    parameter int DATA_W = 8,
    parameter int DEPTH  = 16,
    parameter int AW     = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              wen,
    input  logic [AW-1:0]     waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic [AW-1:0]     raddr,
    output logic [DATA_W-1:0] rdata
);

    logic [DATA_W-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (wen) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/sfifo_param.sv
// rtl/sfifo_param.sv - parametrised single-clock FIFO with count, level flags and error pulses
//
// Purpose: circular-buffer FIFO between a producer and a consumer in one clock domain.
// Optional build macro: SFIFO_FWFT_EN selects first-word-fall-through reads
//   (dout shows mem[rptr] while non-empty, rvalid = !empty, re acknowledges the shown word).
//   Without it, reads are registered with one clock of latency.
// Ports:
//   clk, rst_n          clock, asynchronous active-low reset
//   we, din             write request and data
//   re                  read request (pop / acknowledge)
//   dout, rvalid        read data and its valid flag
//   full, empty         count == DEPTH, count == 0
//   almost_full         count >= AF_LVL
//   almost_empty        count <= AE_LVL
//   count               occupancy 0..DEPTH
//   overflow, underflow one-cycle pulses for a rejected write / read
module sfifo_param
    import sfifo_pkg::*;
#(
    parameter int DATA_W = SFIFO_DATA_W_DEF,
    parameter int DEPTH  = SFIFO_DEPTH_DEF,
    parameter int AF_LVL = DEPTH - 2,
    parameter int AE_LVL = 2
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          we,
    input  logic [DATA_W-1:0]             din,
    input  logic                          re,
    output logic [DATA_W-1:0]             dout,
    output logic                          rvalid,
    output logic                          full,
    output logic                          empty,
    output logic                          almost_full,
    output logic                          almost_empty,
    output logic [sfifo_cnt_w(DEPTH)-1:0] count,
    output logic                          overflow,
    output logic                          underflow
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = sfifo_cnt_w(DEPTH);

    logic [AW-1:0]     wptr;
    logic [AW-1:0]     rptr;
    logic [DATA_W-1:0] rdata;
    logic              push;
    logic              pop;

    // Requests are qualified against the registered flags, so a full FIFO
    // never writes through and an empty one never reads the write data.
    assign push = we && !full;
    assign pop  = re && !empty;

    assign full         = (count == CW'(DEPTH));
    assign empty        = (count == '0);
    assign almost_full  = (count >= CW'(AF_LVL));
    assign almost_empty = (count <= CW'(AE_LVL));

    sfifo_mem #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH),
        .AW     (AW)
    ) u_mem (
        .clk   (clk),
        .wen   (push),
        .waddr (wptr),
        .wdata (din),
        .raddr (rptr),
        .rdata (rdata)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wptr      <= '0;
            rptr      <= '0;
            count     <= '0;
            overflow  <= 1'b0;
            underflow <= 1'b0;
        end else begin
            if (push) begin
                wptr <= wptr + 1'b1;
            end
            if (pop) begin
                rptr <= rptr + 1'b1;
            end
            if (push && !pop) begin
                count <= count + 1'b1;
            end else if (pop && !push) begin
                count <= count - 1'b1;
            end
            overflow  <= we && full;
            underflow <= re && empty;
        end
    end

`ifdef SFIFO_FWFT_EN
    // The head word is presented directly; forced to zero while empty so
    // stale memory contents never leak onto dout.
    assign dout   = empty ? '0 : rdata;
    assign rvalid = !empty;
`else
    logic [DATA_W-1:0] dout_q;
    logic              rvalid_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dout_q   <= '0;
            rvalid_q <= 1'b0;
        end else begin
            if (pop) begin
                dout_q <= rdata;
            end
            rvalid_q <= pop;
        end
    end

    assign dout   = dout_q;
    assign rvalid = rvalid_q;
`endif

endmodule

// File: tb/tb_sfifo_param.sv
// tb/tb_sfifo_param.sv - directed table-driven bench for sfifo_param (default 8x16, registered read)
module tb_sfifo_param;

    logic       clk;
    logic       rst_n;
    logic       we;
    logic       re;
    logic [7:0] din;
    logic [7:0] dout;
    logic       rvalid;
    logic       full;
    logic       empty;
    logic       almost_full;
    logic       almost_empty;
    logic [4:0] count;
    logic       overflow;
    logic       underflow;

    int n_chk  = 0;
    int n_fail = 0;

    sfifo_param #(
        .DATA_W (8),
        .DEPTH  (16),
        .AF_LVL (14),
        .AE_LVL (2)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .we           (we),
        .din          (din),
        .re           (re),
        .dout         (dout),
        .rvalid       (rvalid),
        .full         (full),
        .empty        (empty),
        .almost_full  (almost_full),
        .almost_empty (almost_empty),
        .count        (count),
        .overflow     (overflow),
        .underflow    (underflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic       we;
        logic       re;
        logic [7:0] din;
        logic [4:0] cnt;
        logic [7:0] dout;
        logic       rvalid;
        logic       ovf;
        logic       udf;
    } vec_t;

    vec_t vecs[$];

    task automatic add(input logic w, input logic r, input logic [7:0] d,
                       input logic [4:0] c, input logic [7:0] o,
                       input logic v, input logic ov, input logic ud);
        vec_t t;
        t.we = w; t.re = r; t.din = d; t.cnt = c;
        t.dout = o; t.rvalid = v; t.ovf = ov; t.udf = ud;
        vecs.push_back(t);
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Flags are decoded from the expected count using AF_LVL=14, AE_LVL=2.
    task automatic chk_state(input string tag, input logic [4:0] c, input logic [7:0] o,
                             input logic v, input logic ov, input logic ud);
        chk({tag, " count"},        32'(count),        32'(c));
        chk({tag, " full"},         32'(full),         32'(c == 5'd16));
        chk({tag, " empty"},        32'(empty),        32'(c == 5'd0));
        chk({tag, " almost_full"},  32'(almost_full),  32'(c >= 5'd14));
        chk({tag, " almost_empty"}, 32'(almost_empty), 32'(c <= 5'd2));
        chk({tag, " dout"},         32'(dout),         32'(o));
        chk({tag, " rvalid"},       32'(rvalid),       32'(v));
        chk({tag, " overflow"},     32'(overflow),     32'(ov));
        chk({tag, " underflow"},    32'(underflow),    32'(ud));
    endtask

    task automatic step(input logic w, input logic r, input logic [7:0] d);
        @(negedge clk);
        we = w; re = r; din = d;
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst_n = 1'b0; we = 1'b0; re = 1'b0; din = 8'h00;

        // Fill 0x00..0x0F, then a rejected write of 0xAA while full.
        for (int i = 0; i < 16; i++) add(1, 0, 8'(i), 5'(i + 1), 8'h00, 0, 0, 0);
        add(1, 0, 8'hAA, 5'd16, 8'h00, 0, 1, 0);
        add(0, 0, 8'h00, 5'd16, 8'h00, 0, 0, 0);
        // Drain, then a rejected read.
        for (int i = 0; i < 16; i++) add(0, 1, 8'h00, 5'(15 - i), 8'(i), 1, 0, 0);
        add(0, 1, 8'h00, 5'd0, 8'h0F, 0, 0, 1);
        add(0, 0, 8'h00, 5'd0, 8'h0F, 0, 0, 0);
        // Load 8, stream 20 simultaneous read/write cycles across the wrap, drain.
        for (int i = 0; i < 8; i++)  add(1, 0, 8'(8'h20 + i), 5'(i + 1), 8'h0F, 0, 0, 0);
        for (int j = 0; j < 20; j++) add(1, 1, 8'(8'h28 + j), 5'd8, 8'(8'h20 + j), 1, 0, 0);
        for (int i = 0; i < 8; i++)  add(0, 1, 8'h00, 5'(7 - i), 8'(8'h34 + i), 1, 0, 0);
        // Simultaneous request on empty: push only, underflow, then pop it.
        add(1, 1, 8'h55, 5'd1, 8'h3B, 0, 0, 1);
        add(0, 1, 8'h00, 5'd0, 8'h55, 1, 0, 0);

        repeat (2) @(posedge clk);
        #1;
        chk_state("reset", 5'd0, 8'h00, 0, 0, 0);
        @(negedge clk);
        rst_n = 1'b1;

        foreach (vecs[k]) begin
            step(vecs[k].we, vecs[k].re, vecs[k].din);
            chk_state($sformatf("vec%0d", k), vecs[k].cnt, vecs[k].dout,
                      vecs[k].rvalid, vecs[k].ovf, vecs[k].udf);
        end

        // Load 5 words and pop one so dout is non-zero before the reset.
        for (int i = 0; i < 5; i++) step(1, 0, 8'(8'h60 + i));
        step(0, 1, 8'h00);
        chk_state("pre_rst", 5'd4, 8'h60, 1, 0, 0);
        step(0, 0, 8'h00);
        #2;
        rst_n = 1'b0;
        #1;
        chk_state("async_rst", 5'd0, 8'h00, 0, 0, 0);
        @(negedge clk);
        rst_n = 1'b1;
        step(1, 0, 8'h77);
        chk_state("post_rst_wr", 5'd1, 8'h00, 0, 0, 0);
        step(0, 1, 8'h00);
        chk_state("post_rst_rd", 5'd0, 8'h77, 1, 0, 0);
        step(0, 0, 8'h00);
        chk_state("post_rst_idle", 5'd0, 8'h77, 0, 0, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
